// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
//
// Registered EX-stage ALU with a start/busy/valid handshake.
//   - Single-cycle ops (AND, OR, ADD, SUB, SLT, SLTU, undefined codes, and
//     divide/remainder by zero) complete at the accepting edge. valid_o
//     pulses for the following cycle.
//   - MUL is an iterative shift-add that consumes one multiplier bit per
//     cycle, LSB first.
//   - DIVU/REMU is an iterative restoring divide that produces one quotient
//     bit per cycle, MSB first.
//   - An iterative op takes WIDTH cycles. busy_o is high while it runs, and
//     start_i is ignored during that time.
//
// Ports
//   clk_i     in   1      clock, rising edge
//   rst_i     in   1      asynchronous reset, active low
//   start_i   in   1      request, sampled only while busy_o == 0
//   src1_i    in   WIDTH  operand A, captured on an accepted start
//   src2_i    in   WIDTH  operand B, captured on an accepted start
//   ctrl_i    in   4      opcode, captured on an accepted start
//   busy_o    out  1      iterative op in progress
//   valid_o   out  1      one-cycle pulse: result_o/zero_o were just updated
//   result_o  out  WIDTH  registered result, held until the next completion
//   zero_o    out  1      result_o == 0
// ---------------------------------------------------------------------------
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIVU = 4'd4;
  localparam logic [3:0] OP_REMU = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  // MUL: multiplicand, shifted left each step.
  // DIV: dividend; quotient bits shift in from the right as dividend bits
  //      leave at the top.
  logic [WIDTH-1:0] r_opa;
  // MUL: multiplier, shifted right each step.
  // DIV: divisor, held constant.
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc;      // partial product
  logic [WIDTH:0]   r_rem;      // partial remainder, with one guard bit
  logic             r_is_rem;   // the DIV result is the remainder (REMU)
  logic             r_busy;
  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  // Result of any op that finishes at the accepting edge. DIVU/REMU only
  // reach this path when the divisor is zero. MUL never reaches it.
  function automatic logic [WIDTH-1:0] alu_single(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] res;
    res = '0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_DIVU: res = '1;
      OP_REMU: res = a;
      default: res = '0;
    endcase
    return res;
  endfunction

  logic [WIDTH-1:0] w_single;
  logic             w_is_div;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;
  logic             w_div_ge;
  logic [WIDTH:0]   w_div_rem;
  logic [WIDTH-1:0] w_div_quo;
  logic [WIDTH-1:0] w_fin_res;

  assign w_single = alu_single(ctrl_i, src1_i, src2_i);
  assign w_is_div = (ctrl_i == OP_DIVU) || (ctrl_i == OP_REMU);

  // Shift-add step: add the multiplicand when the current multiplier LSB
  // is set.
  assign w_mul_acc = r_acc + (r_opb[0] ? r_opa : '0);

  // Restoring step: bring in the next dividend bit and try to subtract the
  // divisor. A borrow out of the guard bit means the trial went negative,
  // so the shifted value is kept instead.
  assign w_div_shift = {r_rem[WIDTH-1:0], r_opa[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opb};
  assign w_div_ge    = r_rem[WIDTH] | ~w_div_diff[WIDTH];
  assign w_div_rem   = w_div_ge ? w_div_diff : w_div_shift;
  assign w_div_quo   = {r_opa[WIDTH-2:0], w_div_ge};

  assign w_fin_res = (r_state == S_DIV) ?
                     (r_is_rem ? w_div_rem[WIDTH-1:0] : w_div_quo) :
                     w_mul_acc;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_is_rem <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (ctrl_i == OP_MUL) begin
              r_state <= S_MUL;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_opa   <= src1_i;
              r_opb   <= src2_i;
              r_acc   <= '0;
            end else if (w_is_div && (src2_i != '0)) begin
              r_state  <= S_DIV;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_opa    <= src1_i;
              r_opb    <= src2_i;
              r_rem    <= '0;
              r_is_rem <= (ctrl_i == OP_REMU);
            end else begin
              r_result <= w_single;
              r_zero   <= (w_single == '0);
              r_valid  <= 1'b1;
            end
          end
        end

        S_MUL: begin
          r_acc <= w_mul_acc;
          r_opa <= r_opa << 1;
          r_opb <= r_opb >> 1;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_result <= w_fin_res;
            r_zero   <= (w_fin_res == '0);
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_IDLE;
          end
        end

        S_DIV: begin
          r_rem <= w_div_rem;
          r_opa <= w_div_quo;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_result <= w_fin_res;
            r_zero   <= (w_fin_res == '0);
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign valid_o  = r_valid;
  assign result_o = r_result;
  assign zero_o   = r_zero;

endmodule

// File: tb/tb_alu_multicycle.sv
// ---------------------------------------------------------------------------
// tb_alu_multicycle
//
// Directed vectors for alu_multicycle (WIDTH=32).
//   - The stimulus process pushes each expected result, zero flag and
//     completion cycle into a queue.
//   - A monitor process pops one entry and compares it on every valid_o.
// ---------------------------------------------------------------------------
module tb_alu_multicycle;

  localparam int W = 32;

  localparam logic [3:0] C_AND  = 4'd0;
  localparam logic [3:0] C_OR   = 4'd1;
  localparam logic [3:0] C_ADD  = 4'd2;
  localparam logic [3:0] C_MUL  = 4'd3;
  localparam logic [3:0] C_DIVU = 4'd4;
  localparam logic [3:0] C_REMU = 4'd5;
  localparam logic [3:0] C_SUB  = 4'd6;
  localparam logic [3:0] C_SLT  = 4'd7;
  localparam logic [3:0] C_SLTU = 4'd8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic [3:0]   ctrl;
  logic         busy;
  logic         valid;
  logic [W-1:0] result;
  logic         zero;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .start_i  (start),
    .src1_i   (src1),
    .src2_i   (src2),
    .ctrl_i   (ctrl),
    .busy_o   (busy),
    .valid_o  (valid),
    .result_o (result),
    .zero_o   (zero)
  );

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic         z;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every valid_o pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got result %h at cycle %0d, expected no completion",
                 result, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_zero"}, {31'd0, zero}, {31'd0, e.z});
        chk({e.name, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  // Drive one request, called just after a falling edge while the DUT is
  // idle. lat is the number of extra edges after the accepting edge:
  // 0 for single-cycle ops, W for iterative ones.
  task automatic issue(input string name, input logic [3:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_res, input int lat);
    exp_t e;
    e.name = name;
    e.res  = exp_res;
    e.z    = (exp_res == '0);
    e.cyc  = cyc + 1 + lat;
    q.push_back(e);
    ctrl  = c;
    src1  = a;
    src2  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src1  = $urandom;
    src2  = $urandom;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((busy || q.size() != 0) && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: got %0d outstanding after %0d cycles, expected 0", q.size(), k);
      q.delete();
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    src1  = '0;
    src2  = '0;
    ctrl  = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back single-cycle ops.
    issue("add_5_7", C_ADD, 32'd5, 32'd7, 32'd12, 0);
    issue("sub_5_5", C_SUB, 32'd5, 32'd5, 32'd0, 0);
    issue("and", C_AND, 32'hF0, 32'h3C, 32'h30, 0);
    issue("or", C_OR, 32'hF0, 32'h3C, 32'hFC, 0);
    issue("slt_neg", C_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
    issue("sltu_big", C_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    issue("undef15", 4'd15, 32'h1234, 32'h5678, 32'd0, 0);
    issue("add_wrap", C_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1, 0);
    wait_done();

    // Iterative multiply. busy_o must stay high for exactly W sampled cycles.
    issue("mul_7_6", C_MUL, 32'd7, 32'd6, 32'd42, W);
    k = 0;
    while (busy && k < 100) begin
      k++;
      @(negedge clk);
    end
    chk("mul_busy_cycles", k, W);
    wait_done();
    issue("mul_wrap", C_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, W);
    wait_done();
    issue("mul_ones", C_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, W);
    wait_done();

    // Divide and remainder, including divide by zero.
    issue("divu_100_7", C_DIVU, 32'd100, 32'd7, 32'd14, W);
    wait_done();
    issue("remu_100_7", C_REMU, 32'd100, 32'd7, 32'd2, W);
    wait_done();
    issue("divu_by0", C_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 0);
    issue("remu_by0", C_REMU, 32'd9, 32'd0, 32'd9, 0);
    wait_done();
    issue("divu_max_1", C_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, W);
    wait_done();
    issue("remu_max_16", C_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, W);
    wait_done();

    // A start while busy is ignored, and the operands are unaffected.
    issue("mul_3_3", C_MUL, 32'd3, 32'd3, 32'd9, W);
    repeat (9) @(negedge clk);
    ctrl  = C_ADD;
    src1  = 32'd1;
    src2  = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset in the middle of a divide.
    issue("divu_abort", C_DIVU, 32'd100, 32'd7, 32'd14, W);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue("add_2_2", C_ADD, 32'd2, 32'd2, 32'd4, 0);
    wait_done();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
